// File: rtl/arp_tx_sched.sv
// arp_tx_sched: arbitrates ARP replies and ARP queries (with a timed retry
// engine) into a single registered frame slot for the ARP frame transmitter.
// Optional feature macro: ARP_GRATUITOUS_EN (gratuitous ARP announcements).
module arp_tx_sched #(
    parameter int RETRY_COUNT    = 4,
    parameter int RETRY_INTERVAL = 250000000,
    parameter int TIMER_WIDTH    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic        s_reply_valid,
    output logic        s_reply_ready,
    input  logic [47:0] s_reply_tha,
    input  logic [31:0] s_reply_tpa,
    input  logic        s_query_valid,
    output logic        s_query_ready,
    input  logic [31:0] s_query_ip,
    input  logic        query_cancel,
    input  logic        send_gratuitous,
    output logic        m_frame_valid,
    input  logic        m_frame_ready,
    output logic [47:0] m_eth_dest_mac,
    output logic [47:0] m_eth_src_mac,
    output logic [15:0] m_eth_type,
    output logic [15:0] m_arp_htype,
    output logic [15:0] m_arp_ptype,
    output logic [15:0] m_arp_oper,
    output logic [47:0] m_arp_sha,
    output logic [31:0] m_arp_spa,
    output logic [47:0] m_arp_tha,
    output logic [31:0] m_arp_tpa,
    output logic        query_active,
    output logic        query_timeout,
    output logic        busy
);
    localparam logic [47:0] BCAST_MAC  = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] OPER_REQ   = 16'h0001;
    localparam logic [15:0] OPER_REPLY = 16'h0002;

    typedef struct packed {
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] etype;
        logic [15:0] htype;
        logic [15:0] ptype;
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
    } frame_t;

    // Assemble one Ethernet+ARP header; common fields come from the local identity.
    function automatic frame_t build_frame(input logic [15:0] oper, input logic [47:0] dest,
                                           input logic [47:0] tha, input logic [31:0] tpa,
                                           input logic [47:0] mac, input logic [31:0] ip);
        frame_t f;
        f.dest  = dest;
        f.src   = mac;
        f.etype = 16'h0806;
        f.htype = 16'h0001;
        f.ptype = 16'h0800;
        f.oper  = oper;
        f.sha   = mac;
        f.spa   = ip;
        f.tha   = tha;
        f.tpa   = tpa;
        return f;
    endfunction

    frame_t                 frame_q, frame_d;
    logic                   valid_q, valid_d, slot_query_q, slot_query_d;
    logic                   reply_pending_q, reply_pending_d, reply_ready_q, reply_ready_d;
    logic [47:0]            reply_tha_q, reply_tha_d;
    logic [31:0]            reply_tpa_q, reply_tpa_d;
    logic                   active_q, active_d, send_pending_q, send_pending_d;
    logic                   query_ready_q, query_ready_d, timeout_q, timeout_d;
    logic                   timer_run_q, timer_run_d, busy_q, busy_d;
    logic [31:0]            query_ip_q, query_ip_d;
    logic [7:0]             retries_q, retries_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   grat_pending_s, grat_next_s;
    logic                   frame_hs_s, reply_hs_s, query_hs_s, cancel_s, expire_s;
    logic                   sel_reply_s, sel_grat_s, sel_query_s, query_frame_hs_s;

    assign frame_hs_s       = valid_q && m_frame_ready;
    assign reply_hs_s       = s_reply_valid && reply_ready_q;
    assign query_hs_s       = s_query_valid && query_ready_q;
    assign cancel_s         = query_cancel && active_q;
    assign expire_s         = timer_run_q && (timer_q == '0) && !cancel_s;
    assign sel_reply_s      = !valid_q && reply_pending_q;
    assign sel_grat_s       = !valid_q && !reply_pending_q && grat_pending_s;
    assign sel_query_s      = !valid_q && !reply_pending_q && !grat_pending_s
                              && send_pending_q && !cancel_s;
    assign query_frame_hs_s = frame_hs_s && slot_query_q && active_q && !cancel_s;

`ifdef ARP_GRATUITOUS_EN
    logic grat_pending_q, grat_pending_d;

    // Gratuitous request flag: set by a pulse, cleared when loaded into the slot.
    always_comb begin
        grat_pending_d = grat_pending_q;
        if (sel_grat_s) begin
            grat_pending_d = 1'b0;
        end else if (send_gratuitous) begin
            grat_pending_d = 1'b1;
        end else begin
            grat_pending_d = grat_pending_q;
        end
    end

    // Gratuitous request flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grat_pending_q <= 1'b0;
        end else begin
            grat_pending_q <= grat_pending_d;
        end
    end

    assign grat_pending_s = grat_pending_q;
    assign grat_next_s    = grat_pending_d;
`else
    logic unused_grat_s;
    assign unused_grat_s  = send_gratuitous;
    assign grat_pending_s = 1'b0;
    assign grat_next_s    = 1'b0;
`endif

    // Reply slot: one buffered reply request, freed when its frame is loaded.
    always_comb begin
        reply_pending_d = reply_pending_q;
        reply_tha_d     = reply_tha_q;
        reply_tpa_d     = reply_tpa_q;
        if (sel_reply_s) begin
            reply_pending_d = 1'b0;
        end else if (reply_hs_s) begin
            reply_pending_d = 1'b1;
            reply_tha_d     = s_reply_tha;
            reply_tpa_d     = s_reply_tpa;
        end else begin
            reply_pending_d = reply_pending_q;
        end
        reply_ready_d = !reply_pending_d;
    end

    // Query engine: accepts a query, paces retries with the timer, reports timeout.
    always_comb begin
        active_d       = active_q;
        send_pending_d = send_pending_q;
        retries_d      = retries_q;
        timer_d        = timer_q;
        timer_run_d    = timer_run_q;
        query_ip_d     = query_ip_q;
        timeout_d      = 1'b0;
        if (query_hs_s) begin
            active_d       = 1'b1;
            send_pending_d = 1'b1;
            retries_d      = 8'(RETRY_COUNT - 1);
            query_ip_d     = s_query_ip;
            timer_d        = '0;
            timer_run_d    = 1'b0;
        end else if (cancel_s) begin
            active_d       = 1'b0;
            send_pending_d = 1'b0;
            timer_d        = '0;
            timer_run_d    = 1'b0;
        end else begin
            if (sel_query_s) begin
                send_pending_d = 1'b0;
            end else begin
                send_pending_d = send_pending_q;
            end
            // The retry interval is measured from the query frame handshake.
            if (query_frame_hs_s) begin
                timer_d     = TIMER_WIDTH'(RETRY_INTERVAL - 1);
                timer_run_d = 1'b1;
            end else if (expire_s) begin
                timer_run_d = 1'b0;
                if (retries_q != 8'd0) begin
                    retries_d      = retries_q - 8'd1;
                    send_pending_d = 1'b1;
                end else begin
                    active_d  = 1'b0;
                    timeout_d = 1'b1;
                end
            end else if (timer_run_q) begin
                timer_d = timer_q - TIMER_WIDTH'(1'b1);
            end else begin
                timer_d = timer_q;
            end
        end
        // Ready returns only once the engine has been idle for a full cycle.
        query_ready_d = !(active_d || active_q);
    end

    // Output slot: load only while empty, then hold until the transmitter accepts.
    always_comb begin
        frame_d      = frame_q;
        valid_d      = valid_q;
        slot_query_d = slot_query_q;
        if (valid_q) begin
            valid_d = !frame_hs_s;
        end else if (sel_reply_s) begin
            frame_d      = build_frame(OPER_REPLY, reply_tha_q, reply_tha_q, reply_tpa_q,
                                       local_mac, local_ip);
            valid_d      = 1'b1;
            slot_query_d = 1'b0;
        end else if (sel_grat_s) begin
            frame_d      = build_frame(OPER_REQ, BCAST_MAC, 48'h0, local_ip, local_mac, local_ip);
            valid_d      = 1'b1;
            slot_query_d = 1'b0;
        end else if (sel_query_s) begin
            frame_d      = build_frame(OPER_REQ, BCAST_MAC, 48'h0, query_ip_q, local_mac, local_ip);
            valid_d      = 1'b1;
            slot_query_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
        busy_d = reply_pending_d | active_d | valid_d | grat_next_s;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q         <= '0;
            valid_q         <= 1'b0;
            slot_query_q    <= 1'b0;
            reply_pending_q <= 1'b0;
            reply_ready_q   <= 1'b0;
            reply_tha_q     <= 48'h0;
            reply_tpa_q     <= 32'h0;
            active_q        <= 1'b0;
            send_pending_q  <= 1'b0;
            query_ready_q   <= 1'b0;
            timeout_q       <= 1'b0;
            timer_run_q     <= 1'b0;
            busy_q          <= 1'b0;
            query_ip_q      <= 32'h0;
            retries_q       <= 8'd0;
            timer_q         <= '0;
        end else begin
            frame_q         <= frame_d;
            valid_q         <= valid_d;
            slot_query_q    <= slot_query_d;
            reply_pending_q <= reply_pending_d;
            reply_ready_q   <= reply_ready_d;
            reply_tha_q     <= reply_tha_d;
            reply_tpa_q     <= reply_tpa_d;
            active_q        <= active_d;
            send_pending_q  <= send_pending_d;
            query_ready_q   <= query_ready_d;
            timeout_q       <= timeout_d;
            timer_run_q     <= timer_run_d;
            busy_q          <= busy_d;
            query_ip_q      <= query_ip_d;
            retries_q       <= retries_d;
            timer_q         <= timer_d;
        end
    end

    assign s_reply_ready  = reply_ready_q;
    assign s_query_ready  = query_ready_q;
    assign m_frame_valid  = valid_q;
    assign m_eth_dest_mac = frame_q.dest;
    assign m_eth_src_mac  = frame_q.src;
    assign m_eth_type     = frame_q.etype;
    assign m_arp_htype    = frame_q.htype;
    assign m_arp_ptype    = frame_q.ptype;
    assign m_arp_oper     = frame_q.oper;
    assign m_arp_sha      = frame_q.sha;
    assign m_arp_spa      = frame_q.spa;
    assign m_arp_tha      = frame_q.tha;
    assign m_arp_tpa      = frame_q.tpa;
    assign query_active   = active_q;
    assign query_timeout  = timeout_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_arp_tx_sched.sv
// tb_arp_tx_sched: directed + randomized bench for arp_tx_sched with a
// frame-level reference model (RETRY_COUNT=3, RETRY_INTERVAL=16).
module tb_arp_tx_sched;
    localparam int RC = 3;
    localparam int RI = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] lmac = 48'h0;
    logic [31:0] lip = 32'h0;
    logic        s_reply_valid = 1'b0, s_query_valid = 1'b0;
    logic [47:0] s_reply_tha = 48'h0;
    logic [31:0] s_reply_tpa = 32'h0, s_query_ip = 32'h0;
    logic        query_cancel = 1'b0, send_gratuitous = 1'b0, m_frame_ready = 1'b0;
    logic        s_reply_ready, s_query_ready, m_frame_valid;
    logic [47:0] m_eth_dest_mac, m_eth_src_mac, m_arp_sha, m_arp_tha;
    logic [15:0] m_eth_type, m_arp_htype, m_arp_ptype, m_arp_oper;
    logic [31:0] m_arp_spa, m_arp_tpa;
    logic        query_active, query_timeout, busy;

    arp_tx_sched #(.RETRY_COUNT(RC), .RETRY_INTERVAL(RI), .TIMER_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .local_mac(lmac), .local_ip(lip),
        .s_reply_valid(s_reply_valid), .s_reply_ready(s_reply_ready),
        .s_reply_tha(s_reply_tha), .s_reply_tpa(s_reply_tpa),
        .s_query_valid(s_query_valid), .s_query_ready(s_query_ready), .s_query_ip(s_query_ip),
        .query_cancel(query_cancel), .send_gratuitous(send_gratuitous),
        .m_frame_valid(m_frame_valid), .m_frame_ready(m_frame_ready),
        .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac), .m_eth_type(m_eth_type),
        .m_arp_htype(m_arp_htype), .m_arp_ptype(m_arp_ptype), .m_arp_oper(m_arp_oper),
        .m_arp_sha(m_arp_sha), .m_arp_spa(m_arp_spa), .m_arp_tha(m_arp_tha), .m_arp_tpa(m_arp_tpa),
        .query_active(query_active), .query_timeout(query_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] dest, src, sha, tha;
        logic [15:0] etype, htype, ptype, oper;
        logic [31:0] spa, tpa;
        int          edge_n;
    } fr_t;

    int  n_assert = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  stab_err = 0;
    fr_t got_q[$];
    int  to_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: records handshaken frames and timeout pulses, flags unstable held frames.
    fr_t cur, prev;
    bit  prev_v = 1'b0, prev_hs = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            cur = '{m_eth_dest_mac, m_eth_src_mac, m_arp_sha, m_arp_tha, m_eth_type, m_arp_htype,
                    m_arp_ptype, m_arp_oper, m_arp_spa, m_arp_tpa, cyc + 1};
            if (prev_v && !prev_hs) begin
                if (!m_frame_valid || cur.dest != prev.dest || cur.src != prev.src ||
                    cur.sha != prev.sha || cur.tha != prev.tha || cur.oper != prev.oper ||
                    cur.spa != prev.spa || cur.tpa != prev.tpa || cur.etype != prev.etype)
                    stab_err++;
            end
            if (m_frame_valid && m_frame_ready) got_q.push_back(cur);
            if (query_timeout) to_q.push_back(cyc);
            prev    = cur;
            prev_v  = m_frame_valid;
            prev_hs = m_frame_valid && m_frame_ready;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference frame: 0 = reply, 1 = query, 2 = gratuitous.
    function automatic fr_t exp_fr(input int kind, input logic [47:0] tha, input logic [31:0] tpa);
        fr_t e;
        e.src = lmac; e.sha = lmac; e.spa = lip;
        e.etype = 16'h0806; e.htype = 16'h0001; e.ptype = 16'h0800;
        e.dest  = (kind == 0) ? tha : 48'hFFFF_FFFF_FFFF;
        e.oper  = (kind == 0) ? 16'h0002 : 16'h0001;
        e.tha   = (kind == 0) ? tha : 48'h0;
        e.tpa   = (kind == 2) ? lip : tpa;
        e.edge_n = 0;
        return e;
    endfunction

    task automatic pop_check(input string tag, input fr_t e, output int edge_n);
        fr_t g;
        chk({tag, "_avail"}, 64'(got_q.size() != 0), 64'd1);
        edge_n = -1;
        if (got_q.size() != 0) begin
            g = got_q.pop_front();
            edge_n = g.edge_n;
            chk({tag, "_dest"}, g.dest, e.dest);
            chk({tag, "_src"}, g.src, e.src);
            chk({tag, "_type"}, g.etype, e.etype);
            chk({tag, "_htype"}, g.htype, e.htype);
            chk({tag, "_ptype"}, g.ptype, e.ptype);
            chk({tag, "_oper"}, g.oper, e.oper);
            chk({tag, "_sha"}, g.sha, e.sha);
            chk({tag, "_tha"}, g.tha, e.tha);
            chk({tag, "_spa"}, g.spa, e.spa);
            chk({tag, "_tpa"}, g.tpa, e.tpa);
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int i = 0; i < budget && got_q.size() < n; i++) step(1);
    endtask

    initial begin
        int t0, e1, e2, e3, last_e;
        bit seen, prev_act;
        logic [47:0] tha;
        logic [31:0] tpa;

        lmac = 48'({$urandom(), $urandom()});
        lip  = $urandom();
        // --- reset state ---
        step(3);
        chk("rst_reply_ready", s_reply_ready, 1'b0);
        chk("rst_query_ready", s_query_ready, 1'b0);
        chk("rst_valid", m_frame_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_type", m_eth_type, 16'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_reply_ready_still0", s_reply_ready, 1'b0);
        step(1);
        chk("rel_reply_ready", s_reply_ready, 1'b1);
        chk("rel_query_ready", s_query_ready, 1'b1);

        // --- single reply, ready always high ---
        m_frame_ready = 1'b1;
        s_reply_tha = 48'h02_00_00_00_00_05; s_reply_tpa = 32'h0a00_0005;
        s_reply_valid = 1'b1;
        t0 = cyc;
        step(1);
        s_reply_valid = 1'b0;
        chk("rep_ready_low", s_reply_ready, 1'b0);
        chk("rep_valid_not_yet", m_frame_valid, 1'b0);
        step(1);
        chk("rep_ready_back", s_reply_ready, 1'b1);
        chk("rep_valid_up", m_frame_valid, 1'b1);
        step(1);
        pop_check("rep", exp_fr(0, 48'h02_00_00_00_00_05, 32'h0a00_0005), e1);
        chk("rep_hs_edge", 64'(e1), 64'(t0 + 3));
        step(5);
        chk("rep_single", 64'(got_q.size()), 64'd0);

        // --- randomized replies with random transmitter backpressure ---
        for (int k = 0; k < 4; k++) begin
            lmac = 48'({$urandom(), $urandom()});
            lip  = $urandom();
            tha  = 48'({$urandom(), $urandom()});
            tpa  = $urandom();
            for (int i = 0; i < 10 && !s_reply_ready; i++) step(1);
            s_reply_tha = tha; s_reply_tpa = tpa; s_reply_valid = 1'b1;
            step(1);
            s_reply_valid = 1'b0;
            for (int i = 0; i < 40 && got_q.size() < 1; i++) begin
                m_frame_ready = 1'($urandom_range(0, 1));
                step(1);
            end
            m_frame_ready = 1'b1;
            pop_check("rnd_rep", exp_fr(0, tha, tpa), e1);
            step(2);
        end

        // --- query with full retries and timeout ---
        s_query_ip = 32'h0a00_0009; s_query_valid = 1'b1;
        step(1);
        s_query_valid = 1'b0;
        chk("q_ready_low", s_query_ready, 1'b0);
        seen = 1'b0; prev_act = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            prev_act = query_active;
            step(1);
            if (query_timeout) begin
                seen = 1'b1;
                chk("q_active_falls", query_active, 1'b0);
                chk("q_active_before", prev_act, 1'b1);
                chk("q_ready_at_pulse", s_query_ready, 1'b0);
            end
        end
        chk("q_timeout_seen", seen, 1'b1);
        step(1);
        chk("q_pulse_single", query_timeout, 1'b0);
        chk("q_ready_after", s_query_ready, 1'b1);
        chk("q_frame_count", 64'(got_q.size()), 64'(RC));
        pop_check("q1", exp_fr(1, 48'h0, 32'h0a00_0009), e1);
        pop_check("q2", exp_fr(1, 48'h0, 32'h0a00_0009), e2);
        pop_check("q3", exp_fr(1, 48'h0, 32'h0a00_0009), e3);
        chk("q_gap12", 64'(e2 - e1 >= RI), 64'd1);
        chk("q_gap23", 64'(e3 - e2 >= RI), 64'd1);
        last_e = e3;
        chk("q_to_count", 64'(to_q.size()), 64'd1);
        if (to_q.size() != 0) chk("q_to_edge", 64'(to_q.pop_front()), 64'(last_e + RI));
        step(5);

        // --- cancel five cycles after the first query handshake ---
        s_query_ip = 32'h0a00_0017; s_query_valid = 1'b1;
        step(1);
        s_query_valid = 1'b0;
        wait_frames(1, 20);
        pop_check("c1", exp_fr(1, 48'h0, 32'h0a00_0017), e1);
        step(4);
        query_cancel = 1'b1;
        step(1);
        query_cancel = 1'b0;
        chk("c_active_off", query_active, 1'b0);
        step(1);
        chk("c_ready", s_query_ready, 1'b1);
        step(60);
        chk("c_no_frames", 64'(got_q.size()), 64'd0);
        chk("c_no_timeout", 64'(to_q.size()), 64'd0);
        chk("c_idle", busy, 1'b0);

        // --- backpressure with reply and query pending together ---
        m_frame_ready = 1'b0;
        tha = 48'({$urandom(), $urandom()}); tpa = $urandom();
        s_reply_tha = tha; s_reply_tpa = tpa; s_reply_valid = 1'b1;
        s_query_ip = 32'h0a00_0021; s_query_valid = 1'b1;
        step(1);
        s_reply_valid = 1'b0; s_query_valid = 1'b0;
        step(20);
        chk("bp_held", m_frame_valid, 1'b1);
        chk("bp_held_oper", m_arp_oper, 16'h0002);
        chk("bp_busy", busy, 1'b1);
        chk("bp_nothing_sent", 64'(got_q.size()), 64'd0);
        m_frame_ready = 1'b1;
        wait_frames(2, 20);
        pop_check("bp_rep", exp_fr(0, tha, tpa), e1);
        pop_check("bp_qry", exp_fr(1, 48'h0, 32'h0a00_0021), e2);
        chk("bp_bubble", 64'(e2 - e1), 64'd2);
        query_cancel = 1'b1;
        step(1);
        query_cancel = 1'b0;
        step(40);
        chk("bp_drained", 64'(got_q.size()), 64'd0);
        chk("bp_no_timeout", 64'(to_q.size()), 64'd0);

        // --- reset in the middle of a retry wait ---
        s_query_ip = 32'h0a00_0033; s_query_valid = 1'b1;
        step(1);
        s_query_valid = 1'b0;
        wait_frames(2, 100);
        pop_check("r1", exp_fr(1, 48'h0, 32'h0a00_0033), e1);
        pop_check("r2", exp_fr(1, 48'h0, 32'h0a00_0033), e2);
        step(8);
        #1 rst_n = 1'b0;
        #1;
        chk("r_valid0", m_frame_valid, 1'b0);
        chk("r_active0", query_active, 1'b0);
        chk("r_qready0", s_query_ready, 1'b0);
        chk("r_rready0", s_reply_ready, 1'b0);
        chk("r_busy0", busy, 1'b0);
        chk("r_oper0", m_arp_oper, 16'h0);
        step(3);
        rst_n = 1'b1;
        step(1);
        chk("r_rready1", s_reply_ready, 1'b1);
        chk("r_qready1", s_query_ready, 1'b1);
        step(60);
        chk("r_no_frames", 64'(got_q.size()), 64'd0);
        chk("r_no_timeout", 64'(to_q.size()), 64'd0);

        // --- gratuitous request together with a reply ---
        tha = 48'({$urandom(), $urandom()}); tpa = $urandom();
        s_reply_tha = tha; s_reply_tpa = tpa; s_reply_valid = 1'b1; send_gratuitous = 1'b1;
        step(1);
        s_reply_valid = 1'b0; send_gratuitous = 1'b0;
        step(20);
`ifdef ARP_GRATUITOUS_EN
        chk("g_count", 64'(got_q.size()), 64'd2);
        pop_check("g_rep", exp_fr(0, tha, tpa), e1);
        pop_check("g_grat", exp_fr(2, 48'h0, 32'h0), e2);
`else
        chk("g_count", 64'(got_q.size()), 64'd1);
        pop_check("g_rep", exp_fr(0, tha, tpa), e1);
`endif
        chk("stability", 64'(stab_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/arp_tx_sched.md
Name: arp_tx_sched

Overview:
- Sequencer and arbiter feeding the ARP frame transmitter's parallel-field input (s_frame_* side) from two requesters.
- Requester 1: ARP replies from the receive path.
- Requester 2: ARP queries from the cache-miss path, each with a timed retry engine.
- Builds complete Ethernet+ARP header fields, holds them in a single registered output slot, and reports query timeout.

Parameters:
RETRY_COUNT, 4, total query transmissions before timeout (legal range 1..255)
RETRY_INTERVAL, 250000000, clock cycles between a query frame handshake and its retry
TIMER_WIDTH, 32, width of retry timer; RETRY_INTERVAL must fit

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
local_mac  in  48  own MAC, sampled when the output slot loads
local_ip  in  32  own IP, sampled when the output slot loads
s_reply_valid  in  1  reply request valid
s_reply_ready  out  1  reply request ready
s_reply_tha  in  48  requester MAC (reply target)
s_reply_tpa  in  32  requester IP
s_query_valid  in  1  query request valid
s_query_ready  out  1  query request ready
s_query_ip  in  32  IP to resolve
query_cancel  in  1  pulse: address resolved, stop retries
send_gratuitous  in  1  pulse: gratuitous ARP (see Optional Feature)
m_frame_valid  out  1  frame valid to transmitter
m_frame_ready  in  1  transmitter ready
m_eth_dest_mac, m_eth_src_mac  out  48 each  Ethernet addresses
m_eth_type  out  16  Ethernet type
m_arp_htype, m_arp_ptype, m_arp_oper  out  16 each  ARP fixed fields
m_arp_sha, m_arp_tha  out  48 each  ARP sender/target MAC
m_arp_spa, m_arp_tpa  out  32 each  ARP sender/target IP
query_active  out  1  query resolution in progress
query_timeout  out  1  one-cycle pulse, retries exhausted
busy  out  1  any work pending or frame in output slot

Behaviour:
- Reset (rst_n low, async): all outputs 0, including both readys; all pending flags, timer and counters cleared. First cycle after release: s_reply_ready=1, s_query_ready=1.
- Reply slot (one entry):
  - s_reply_ready registered, =!reply_pending.
  - Handshake latches tha/tpa and sets reply_pending.
- Query engine:
  - s_query_ready registered, =!query_active.
  - Handshake latches ip; sets query_active and query_send_pending; retries_left=RETRY_COUNT-1.
- Output slot:
  - Loads only when m_frame_valid=0 (one bubble after each transmitter handshake).
  - Priority: reply > gratuitous > query_send_pending. The chosen pending flag clears on load.
  - Latency: request handshake at edge T, m_frame_valid high after edge T+1.
  - m_frame_valid and all fields stay stable until m_frame_valid&&m_frame_ready.
- Common fields on every frame:
  - eth_src=sha=local_mac, type=0x0806, htype=1, ptype=0x0800, spa=local_ip.
- Reply frame: dest=tha=reply_tha, oper=2, tpa=reply_tpa.
- Query frame: dest=ff:ff:ff:ff:ff:ff, oper=1, tha=0, tpa=query_ip.
- Retry timer:
  - Loaded with RETRY_INTERVAL-1 on the handshake of a query frame; decrements each cycle while query_active.
  - At 0 with retries_left>0: retries_left-- and query_send_pending=1.
  - At 0 with retries_left=0: query_active=0 and query_timeout pulses for 1 cycle. s_query_ready rises the next cycle.
- query_cancel:
  - While query_active: clears query_active, query_send_pending and timer; no timeout pulse.
  - A query frame already in the output slot still completes its handshake.
  - Ignored when not active.
  - Cancel on the same cycle as timer expiry: cancel wins, no pulse.
- Reply arriving while a query retry is due: reply sent first, query retry next free slot. Retry timer restarts only at that query handshake.
- busy = reply_pending | query_active | m_frame_valid | gratuitous_pending.

Optional Feature:
ARP_GRATUITOUS_EN
- Defined: a send_gratuitous pulse sets gratuitous_pending (re-pulse while pending is absorbed). Frame sent: dest=broadcast, oper=1, tha=0, tpa=spa=local_ip. No retries.
- Undefined: send_gratuitous ignored, gratuitous_pending constant 0, no related logic.

Test Plan:
- Bench parameters: RETRY_COUNT=3, RETRY_INTERVAL=16.
- Reply tha=02:00:00:00:00:05, tpa=10.0.0.5, m_frame_ready=1 -> one frame, m_frame_valid 2 cycles after handshake: dest=02:00:00:00:00:05, oper=2, sha=local_mac, spa=local_ip; s_reply_ready low 1 cycle, then high.
- Query ip=10.0.0.9, ready always 1, no cancel -> 3 broadcast frames (oper=1, tpa=10.0.0.9, tha=0), handshakes spaced ≥16 cycles apart; query_timeout single pulse 16 cycles after third handshake; query_active falls same edge.
- Query started, query_cancel 5 cycles after first handshake -> no further frames, no timeout pulse, s_query_ready=1 next cycle.
- m_frame_ready held 0 for 20 cycles with reply and query pending -> reply frame held stable throughout; query frame follows after bubble.
- rst_n low mid-retry (timer=7, retries_left=1) -> all outputs 0 immediately, no frames or timeout after release, readys high one cycle after release.
- ARP_GRATUITOUS_EN defined, send_gratuitous plus reply on the same cycle -> reply frame first, then gratuitous frame tpa=spa=local_ip, dest broadcast; undefined -> only reply frame.
